// File: rtl/n_term_dsp_loopback_cfg_pkg.sv
// n_term_pkg: shared definitions for the north-terminal DSP loopback block.
//   - mode_e       : per-group mapping code (reversed / straight / tie-0 / tie-1)
//   - CFG_BITS     : configuration chain length (2 bits x 5 groups)
//   - G_*          : group indices into the active configuration word
//   - group_mode() : extracts the 2-bit mode of one group from a config word
package n_term_pkg;

    localparam int CFG_BITS = 10;

    typedef enum logic [1:0] {
        MODE_REV      = 2'b00,
        MODE_STRAIGHT = 2'b01,
        MODE_TIE0     = 2'b10,
        MODE_TIE1     = 2'b11
    } mode_e;

    localparam int G_S1  = 0;
    localparam int G_S2  = 1;
    localparam int G_S2B = 2;
    localparam int G_S4  = 3;
    localparam int G_SS4 = 4;

    // Group g occupies config bits [2g+1:2g].
    function automatic logic [1:0] group_mode(input logic [CFG_BITS-1:0] cfg, input int g);
        return cfg[2*g +: 2];
    endfunction

endpackage

// File: rtl/loopback_group_mux.sv
// loopback_group_mux: maps one northbound wire group onto its southbound group.
// Ports:
//   in_bus  [W] : northbound wire ends of this group
//   mode    [2] : mapping code (see n_term_pkg::mode_e)
//   out_bus [W] : southbound wire starts of this group
module loopback_group_mux
    import n_term_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] in_bus,
    input  logic [1:0]   mode,
    output logic [W-1:0] out_bus
);

    logic [W-1:0] rev_s;
    logic [W-1:0] out_s;

    // Bit-reversed copy of the input group.
    always_comb begin
        rev_s = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            rev_s[i] = in_bus[W-1-i];
        end
    end

    // Mode selection.
    always_comb begin
        out_s = {W{1'b0}};
        case (mode_e'(mode))
            MODE_REV:      out_s = rev_s;
            MODE_STRAIGHT: out_s = in_bus;
            MODE_TIE0:     out_s = {W{1'b0}};
            MODE_TIE1:     out_s = {W{1'b1}};
            default:       out_s = {W{1'b0}};
        endcase
    end

    assign out_bus = out_s;

endmodule

// File: rtl/n_term_dsp_loopback_cfg.sv
// n_term_dsp_loopback_cfg: north-terminal loopback at the top of a DSP column.
// Northbound wires are turned back into southbound starts; each of the five
// groups is mapped according to a 2-bit mode held in an active config word,
// loaded from a serial shift chain by a commit pulse.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   N1END/N2MID/N2END/N4END/NN4END : northbound inputs
//   S1BEG/S2BEG/S2BEGb/S4BEG/SS4BEG: southbound outputs
//   CONF_EN, CONFin     : shift enable and serial data in
//   CONFout             : chain MSB, feeds the next tile
//   CONF_LOAD           : commit chain -> active config (needs CFG_BITS shifts)
//   CONF_ERR            : sticky flag, set by a commit with too few shifts
// Build option: define N_TERM_REGISTERED_LOOPBACK_EN to register the five
// output buses (1-cycle latency, reset to 0). Config timing is unaffected.
module n_term_dsp_loopback_cfg
    import n_term_pkg::*;
#(
    parameter int W1 = 4,
    parameter int W2 = 8,
    parameter int W4 = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [W1-1:0] N1END,
    input  logic [W2-1:0] N2MID,
    input  logic [W2-1:0] N2END,
    input  logic [W4-1:0] N4END,
    input  logic [W4-1:0] NN4END,
    output logic [W1-1:0] S1BEG,
    output logic [W2-1:0] S2BEG,
    output logic [W2-1:0] S2BEGb,
    output logic [W4-1:0] S4BEG,
    output logic [W4-1:0] SS4BEG,
    input  logic          CONF_EN,
    input  logic          CONFin,
    output logic          CONFout,
    input  logic          CONF_LOAD,
    output logic          CONF_ERR
);

    localparam logic [3:0] CNT_FULL = 4'(CFG_BITS);

    logic [CFG_BITS-1:0] chain_r;
    logic [CFG_BITS-1:0] cfg_r;
    logic [3:0]          cnt_r;
    logic                err_r;

    logic [3:0]          cnt_next_s;
    logic                full_s;
    logic                commit_s;
    logic                short_s;

    logic [W1-1:0]       s1_s;
    logic [W2-1:0]       s2_s;
    logic [W2-1:0]       s2b_s;
    logic [W4-1:0]       s4_s;
    logic [W4-1:0]       ss4_s;

    // Commit qualification and next shift-count (saturating at CFG_BITS).
    always_comb begin
        full_s     = (cnt_r == CNT_FULL);
        commit_s   = CONF_LOAD & full_s;
        short_s    = CONF_LOAD & ~full_s;
        cnt_next_s = cnt_r;
        if (commit_s) begin
            // A shift in the commit cycle already counts toward the next load.
            cnt_next_s = CONF_EN ? 4'd1 : 4'd0;
        end else if (CONF_EN && !full_s) begin
            cnt_next_s = cnt_r + 4'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Config chain, active config, shift counter and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            chain_r <= {CFG_BITS{1'b0}};
            cfg_r   <= {CFG_BITS{1'b0}};
            cnt_r   <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            if (CONF_EN) begin
                chain_r <= {chain_r[CFG_BITS-2:0], CONFin};
            end
            // Commit captures the pre-shift chain even when shifting this edge.
            if (commit_s) begin
                cfg_r <= chain_r;
            end
            if (short_s) begin
                err_r <= 1'b1;
            end
            cnt_r <= cnt_next_s;
        end
    end

    assign CONFout  = chain_r[CFG_BITS-1];
    assign CONF_ERR = err_r;

    loopback_group_mux #(.W(W1)) u_mux_s1 (
        .in_bus (N1END),
        .mode   (group_mode(cfg_r, G_S1)),
        .out_bus(s1_s)
    );

    loopback_group_mux #(.W(W2)) u_mux_s2 (
        .in_bus (N2MID),
        .mode   (group_mode(cfg_r, G_S2)),
        .out_bus(s2_s)
    );

    loopback_group_mux #(.W(W2)) u_mux_s2b (
        .in_bus (N2END),
        .mode   (group_mode(cfg_r, G_S2B)),
        .out_bus(s2b_s)
    );

    loopback_group_mux #(.W(W4)) u_mux_s4 (
        .in_bus (N4END),
        .mode   (group_mode(cfg_r, G_S4)),
        .out_bus(s4_s)
    );

    loopback_group_mux #(.W(W4)) u_mux_ss4 (
        .in_bus (NN4END),
        .mode   (group_mode(cfg_r, G_SS4)),
        .out_bus(ss4_s)
    );

`ifdef N_TERM_REGISTERED_LOOPBACK_EN
    logic [W1-1:0] s1_r;
    logic [W2-1:0] s2_r;
    logic [W2-1:0] s2b_r;
    logic [W4-1:0] s4_r;
    logic [W4-1:0] ss4_r;

    // Output registers: one cycle behind inputs and config.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_r  <= {W1{1'b0}};
            s2_r  <= {W2{1'b0}};
            s2b_r <= {W2{1'b0}};
            s4_r  <= {W4{1'b0}};
            ss4_r <= {W4{1'b0}};
        end else begin
            s1_r  <= s1_s;
            s2_r  <= s2_s;
            s2b_r <= s2b_s;
            s4_r  <= s4_s;
            ss4_r <= ss4_s;
        end
    end

    assign S1BEG  = s1_r;
    assign S2BEG  = s2_r;
    assign S2BEGb = s2b_r;
    assign S4BEG  = s4_r;
    assign SS4BEG = ss4_r;
`else
    assign S1BEG  = s1_s;
    assign S2BEG  = s2_s;
    assign S2BEGb = s2b_s;
    assign S4BEG  = s4_s;
    assign SS4BEG = ss4_s;
`endif

endmodule

// File: tb/tb_n_term_dsp_loopback_cfg.sv
// Self-checking bench for n_term_dsp_loopback_cfg: directed scenarios followed
// by randomized traffic, all compared against a behavioural model.
module tb_n_term_dsp_loopback_cfg;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  N1END = 4'h0;
    logic [7:0]  N2MID = 8'h00;
    logic [7:0]  N2END = 8'h00;
    logic [15:0] N4END = 16'h0000;
    logic [15:0] NN4END = 16'h0000;
    logic [3:0]  S1BEG;
    logic [7:0]  S2BEG;
    logic [7:0]  S2BEGb;
    logic [15:0] S4BEG;
    logic [15:0] SS4BEG;
    logic        CONF_EN = 1'b0;
    logic        CONFin = 1'b0;
    logic        CONFout;
    logic        CONF_LOAD = 1'b0;
    logic        CONF_ERR;

    int checks = 0;
    int failures = 0;

    // Model state
    int m_chain = 0;
    int m_cnt = 0;
    int m_cfg = 0;
    int m_err = 0;
    logic [15:0] m_reg_out [5];

    n_term_dsp_loopback_cfg dut (
        .CLK(CLK), .RST(RST),
        .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END), .NN4END(NN4END),
        .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG), .SS4BEG(SS4BEG),
        .CONF_EN(CONF_EN), .CONFin(CONFin), .CONFout(CONFout),
        .CONF_LOAD(CONF_LOAD), .CONF_ERR(CONF_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] map_bus(input logic [15:0] in_v, input int w, input int mode);
        logic [15:0] o;
        o = 16'h0000;
        for (int i = 0; i < w; i++) begin
            case (mode)
                0:       o[i] = in_v[w-1-i];
                1:       o[i] = in_v[i];
                2:       o[i] = 1'b0;
                default: o[i] = 1'b1;
            endcase
        end
        return o;
    endfunction

    function automatic int mode_of(input int cfg, input int g);
        return (cfg >> (2*g)) & 3;
    endfunction

    function automatic logic [15:0] exp_now(input int g, input int cfg);
        case (g)
            0:       return map_bus(16'(N1END), 4, mode_of(cfg, 0));
            1:       return map_bus(16'(N2MID), 8, mode_of(cfg, 1));
            2:       return map_bus(16'(N2END), 8, mode_of(cfg, 2));
            3:       return map_bus(N4END, 16, mode_of(cfg, 3));
            default: return map_bus(NN4END, 16, mode_of(cfg, 4));
        endcase
    endfunction

    // Model update for one rising edge, from the values driven into it.
    task automatic model_edge();
        int ld_ok;
        for (int g = 0; g < 5; g++) begin
            m_reg_out[g] = RST ? 16'h0000 : exp_now(g, m_cfg);
        end
        if (RST) begin
            m_chain = 0; m_cnt = 0; m_cfg = 0; m_err = 0;
        end else begin
            ld_ok = (CONF_LOAD && m_cnt == 10) ? 1 : 0;
            if (CONF_LOAD && m_cnt < 10) m_err = 1;
            if (ld_ok != 0) m_cfg = m_chain;
            if (CONF_EN) m_chain = (m_chain * 2 + int'(CONFin)) % 1024;
            if (ld_ok != 0) m_cnt = CONF_EN ? 1 : 0;
            else if (CONF_EN) m_cnt = (m_cnt + 1 > 10) ? 10 : m_cnt + 1;
        end
    endtask

    task automatic check_all();
        logic [15:0] e [5];
        for (int g = 0; g < 5; g++) begin
`ifdef N_TERM_REGISTERED_LOOPBACK_EN
            e[g] = m_reg_out[g];
`else
            e[g] = exp_now(g, m_cfg);
`endif
        end
        check_eq("s1beg",  16'(S1BEG),  e[0]);
        check_eq("s2beg",  16'(S2BEG),  e[1]);
        check_eq("s2begb", 16'(S2BEGb), e[2]);
        check_eq("s4beg",  S4BEG,       e[3]);
        check_eq("ss4beg", SS4BEG,      e[4]);
        check_eq("confout", 16'(CONFout), 16'((m_chain >> 9) & 1));
        check_eq("conf_err", 16'(CONF_ERR), 16'(m_err));
    endtask

    // One clock: drive controls at the falling edge, check at the next one.
    task automatic step(input logic rst, input logic en, input logic din, input logic load);
        RST = rst; CONF_EN = en; CONFin = din; CONF_LOAD = load;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic shift_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) step(1'b0, 1'b1, w[i], 1'b0);
    endtask

    initial begin
        logic [9:0] pat;
        @(negedge CLK);
        N1END = 4'b0001; N2MID = 8'h01; N2END = 8'h0F; N4END = 16'h0003; NN4END = 16'h1234;

        // Reset: outputs in reversed mode
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef N_TERM_REGISTERED_LOOPBACK_EN
        check_eq("rst_reg_s1", 16'(S1BEG), 16'h0000);
        check_eq("rst_reg_ss4", SS4BEG, 16'h0000);
`else
        check_eq("rst_s1", 16'(S1BEG), 16'h0008);
        check_eq("rst_s4", S4BEG, 16'hC000);
`endif
        check_eq("rst_err", 16'(CONF_ERR), 16'h0000);
        check_eq("rst_confout", 16'(CONFout), 16'h0000);

        // Full load
        step(1'b0, 1'b0, 1'b0, 1'b0);
        shift_word(10'b11_10_00_00_01);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`ifndef N_TERM_REGISTERED_LOOPBACK_EN
        check_eq("full_s1", 16'(S1BEG), 16'h0001);
        check_eq("full_s2", 16'(S2BEG), 16'h0080);
        check_eq("full_s2b", 16'(S2BEGb), 16'h00F0);
        check_eq("full_s4", S4BEG, 16'h0000);
        check_eq("full_ss4", SS4BEG, 16'hFFFF);
`endif
        check_eq("full_err", 16'(CONF_ERR), 16'h0000);

        // Short load then completion
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("short_err", 16'(CONF_ERR), 16'h0001);
`ifndef N_TERM_REGISTERED_LOOPBACK_EN
        check_eq("short_s1", 16'(S1BEG), 16'h0008);
`endif
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("short2_err", 16'(CONF_ERR), 16'h0001);
        check_eq("short2_s1", 16'(S1BEG), 16'h000F);

        // Chain pass-through
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shift_word(10'b1000000000);
        check_eq("pass_10", 16'(CONFout), 16'h0001);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("pass_11", 16'(CONFout), 16'h0000);

        // Simultaneous shift+commit: counter restarts at 1, so 9 more shifts suffice
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pat = 10'b0101010101;
        shift_word(pat);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("simul_s1", 16'(S1BEG), 16'h0001);
        check_eq("simul_s2", 16'(S2BEG), 16'h0001);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("simul_err", 16'(CONF_ERR), 16'h0000);

`ifdef N_TERM_REGISTERED_LOOPBACK_EN
        // Registered latency on S2BEG in reversed mode
        step(1'b1, 1'b0, 1'b0, 1'b0);
        N2MID = 8'h01;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reg_s2_a", 16'(S2BEG), 16'h0080);
        N2MID = 8'h80;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reg_s2_b", 16'(S2BEG), 16'h0001);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic en, ld, rs;
            N1END = 4'($urandom); N2MID = 8'($urandom); N2END = 8'($urandom);
            N4END = 16'($urandom); NN4END = 16'($urandom);
            rs = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 99) < 60);
            ld = ($urandom_range(0, 99) < 12);
            step(rs, en, en ? 1'($urandom) : 1'bx, ld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
